// File: rtl/valu_scheduler_if.sv
// ---------------------------------------------------------------------------
// valu_scheduler_if
//   Bundle of every handshake/data signal around valu_scheduler: the warp
//   request side, the vector-ALU side and the result side.
//
//   Parameters:
//     THREADS  lanes per warp (vector ALU width)
//     WARPS    number of requesting warps (power of two, >= 2)
//     OP_W     width of one ALU opcode
//
//   Signal groups:
//     req_*  warp requests in, one-hot grant (req_ready) out
//     alu_*  operands/opcode to the vector ALU, results/flags back
//     rsp_*  registered result with ready/valid handshake
//
//   Modports:
//     slave   the scheduler's view
//     master  the surrounding logic (issue stage, ALU, consumer)
// ---------------------------------------------------------------------------
interface valu_scheduler_if #(
  parameter int THREADS = 4,
  parameter int WARPS   = 4,
  parameter int OP_W    = 4
);
  localparam int WID = $clog2(WARPS);

  // warp request side
  logic [WARPS-1:0]                    req_valid;
  logic [WARPS-1:0]                    req_ready;
  logic [WARPS-1:0][OP_W-1:0]          req_op;
  logic [WARPS-1:0][THREADS-1:0][31:0] req_porta;
  logic [WARPS-1:0][THREADS-1:0][31:0] req_portb;
  logic [WARPS-1:0][THREADS-1:0]       req_mask;

  // vector ALU side
  logic [THREADS-1:0][OP_W-1:0]        alu_op;
  logic [THREADS-1:0][31:0]            alu_porta;
  logic [THREADS-1:0][31:0]            alu_portb;
  logic [THREADS-1:0][31:0]            alu_out;
  logic [THREADS-1:0]                  alu_nf;
  logic [THREADS-1:0]                  alu_zf;
  logic [THREADS-1:0]                  alu_of;

  // result side
  logic                                rsp_valid;
  logic                                rsp_ready;
  logic [WID-1:0]                      rsp_warp;
  logic [THREADS-1:0][31:0]            rsp_out;
  logic [THREADS-1:0]                  rsp_nf;
  logic [THREADS-1:0]                  rsp_zf;
  logic [THREADS-1:0]                  rsp_of;
  logic [THREADS-1:0]                  rsp_mask;
  logic                                rsp_any_of;

  modport slave (
    input  req_valid, req_op, req_porta, req_portb, req_mask,
    output req_ready,
    output alu_op, alu_porta, alu_portb,
    input  alu_out, alu_nf, alu_zf, alu_of,
    output rsp_valid, rsp_warp, rsp_out, rsp_nf, rsp_zf, rsp_of, rsp_mask, rsp_any_of,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_porta, req_portb, req_mask,
    input  req_ready,
    input  alu_op, alu_porta, alu_portb,
    output alu_out, alu_nf, alu_zf, alu_of,
    input  rsp_valid, rsp_warp, rsp_out, rsp_nf, rsp_zf, rsp_of, rsp_mask, rsp_any_of,
    output rsp_ready
  );
endinterface

// File: rtl/valu_scheduler.sv
// ---------------------------------------------------------------------------
// valu_scheduler
//   Round-robin issue scheduler sharing one vector ALU among WARPS warps.
//   Each cycle at most one warp is granted; its opcode, operands and lane
//   mask are registered into the operand stage (S1), which drives the
//   vector ALU combinationally. The ALU result is captured into the result
//   stage (S2) and returned through a ready/valid handshake.
//
//   Ports:
//     CLK    clock, all state changes on the rising edge
//     nRST   asynchronous active-low reset
//     bus    valu_scheduler_if.slave (req_*, alu_*, rsp_* groups)
//
//   Pipeline:
//     an op accepted at edge N is presented on rsp_valid after edge N+1;
//     one op per cycle while rsp_ready stays high; S2 full and not
//     draining stalls S1, and with S1 also full every req_ready is 0.
// ---------------------------------------------------------------------------
module valu_scheduler #(
  parameter int THREADS = 4,
  parameter int WARPS   = 4,
  parameter int OP_W    = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  valu_scheduler_if.slave bus
);

  localparam int             WID      = $clog2(WARPS);
  // Pointer resets to the last warp so warp 0 is searched first.
  localparam logic [WID-1:0] RR_RESET = WID'(WARPS - 1);

  // operand stage (S1)
  logic                           s1_valid_q, s1_valid_d;
  logic [WID-1:0]                 s1_warp_q,  s1_warp_d;
  logic [OP_W-1:0]                s1_op_q,    s1_op_d;
  logic [THREADS-1:0][31:0]       s1_porta_q, s1_porta_d;
  logic [THREADS-1:0][31:0]       s1_portb_q, s1_portb_d;
  logic [THREADS-1:0]             s1_mask_q,  s1_mask_d;

  // result stage (S2)
  logic                           s2_valid_q, s2_valid_d;
  logic [WID-1:0]                 s2_warp_q,  s2_warp_d;
  logic [THREADS-1:0][31:0]       s2_out_q,   s2_out_d;
  logic [THREADS-1:0]             s2_nf_q,    s2_nf_d;
  logic [THREADS-1:0]             s2_zf_q,    s2_zf_d;
  logic [THREADS-1:0]             s2_of_q,    s2_of_d;
  logic [THREADS-1:0]             s2_mask_q,  s2_mask_d;

  // arbitration state
  logic [WID-1:0]                 rr_ptr_q,   rr_ptr_d;

  // combinational control
  logic                           s2_load_s;
  logic                           s1_free_s;
  logic                           grant_any_s;
  logic [WID-1:0]                 grant_idx_s;
  logic [WID-1:0]                 cand_s;
  logic [WARPS-1:0]               grant_s;
  logic [THREADS-1:0][OP_W-1:0]   alu_op_s;
  logic [THREADS-1:0][31:0]       alu_porta_s;
  logic [THREADS-1:0][31:0]       alu_portb_s;
  logic [THREADS-1:0][31:0]       alu_out_masked_s;

  // S1 moves into S2 whenever S2 is empty or being drained this cycle;
  // S1 can accept whenever it is empty or moving on.
  assign s2_load_s = s1_valid_q && (!s2_valid_q || bus.rsp_ready);
  assign s1_free_s = !s1_valid_q || s2_load_s;

  // Round-robin search starting just after the last granted warp; the
  // pointer sum wraps naturally because WARPS is a power of two.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = rr_ptr_q;
    cand_s      = '0;
    for (int k = 1; k <= WARPS; k++) begin
      cand_s = rr_ptr_q + WID'(k);
      if (s1_free_s && !grant_any_s && bus.req_valid[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // One-hot grant vector presented as req_ready.
  always_comb begin
    grant_s = '0;
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Operand stage next state: load on grant, empty when drained to S2.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_warp_d  = s1_warp_q;
    s1_op_d    = s1_op_q;
    s1_porta_d = s1_porta_q;
    s1_portb_d = s1_portb_q;
    s1_mask_d  = s1_mask_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_any_s) begin
      s1_valid_d = 1'b1;
      s1_warp_d  = grant_idx_s;
      s1_op_d    = bus.req_op[grant_idx_s];
      s1_porta_d = bus.req_porta[grant_idx_s];
      s1_portb_d = bus.req_portb[grant_idx_s];
      s1_mask_d  = bus.req_mask[grant_idx_s];
      rr_ptr_d   = grant_idx_s;
    end else if (s2_load_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Vector ALU drive: one opcode for all lanes, inactive lanes see zeros.
  always_comb begin
    alu_op_s    = '0;
    alu_porta_s = '0;
    alu_portb_s = '0;
    for (int i = 0; i < THREADS; i++) begin
      alu_op_s[i] = s1_op_q;
      if (s1_mask_q[i]) begin
        alu_porta_s[i] = s1_porta_q[i];
        alu_portb_s[i] = s1_portb_q[i];
      end else begin
        alu_porta_s[i] = 32'd0;
        alu_portb_s[i] = 32'd0;
      end
    end
  end

  // ALU lane results forced to zero on lanes outside the S1 mask.
  always_comb begin
    alu_out_masked_s = '0;
    for (int i = 0; i < THREADS; i++) begin
      if (s1_mask_q[i]) begin
        alu_out_masked_s[i] = bus.alu_out[i];
      end else begin
        alu_out_masked_s[i] = 32'd0;
      end
    end
  end

  // Result stage next state: capture from S1, clear when consumed, else hold.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_warp_d  = s2_warp_q;
    s2_out_d   = s2_out_q;
    s2_nf_d    = s2_nf_q;
    s2_zf_d    = s2_zf_q;
    s2_of_d    = s2_of_q;
    s2_mask_d  = s2_mask_q;
    if (s2_load_s) begin
      s2_valid_d = 1'b1;
      s2_warp_d  = s1_warp_q;
      s2_out_d   = alu_out_masked_s;
      s2_nf_d    = bus.alu_nf & s1_mask_q;
      s2_zf_d    = bus.alu_zf & s1_mask_q;
      s2_of_d    = bus.alu_of & s1_mask_q;
      s2_mask_d  = s1_mask_q;
    end else if (bus.rsp_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // State registers; reset discards any in-flight op without a response.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q <= 1'b0;
      s1_warp_q  <= '0;
      s1_op_q    <= '0;
      s1_porta_q <= '0;
      s1_portb_q <= '0;
      s1_mask_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_warp_q  <= '0;
      s2_out_q   <= '0;
      s2_nf_q    <= '0;
      s2_zf_q    <= '0;
      s2_of_q    <= '0;
      s2_mask_q  <= '0;
      rr_ptr_q   <= RR_RESET;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_warp_q  <= s1_warp_d;
      s1_op_q    <= s1_op_d;
      s1_porta_q <= s1_porta_d;
      s1_portb_q <= s1_portb_d;
      s1_mask_q  <= s1_mask_d;
      s2_valid_q <= s2_valid_d;
      s2_warp_q  <= s2_warp_d;
      s2_out_q   <= s2_out_d;
      s2_nf_q    <= s2_nf_d;
      s2_zf_q    <= s2_zf_d;
      s2_of_q    <= s2_of_d;
      s2_mask_q  <= s2_mask_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.alu_op     = alu_op_s;
  assign bus.alu_porta  = alu_porta_s;
  assign bus.alu_portb  = alu_portb_s;
  assign bus.rsp_valid  = s2_valid_q;
  assign bus.rsp_warp   = s2_warp_q;
  assign bus.rsp_out    = s2_out_q;
  assign bus.rsp_nf     = s2_nf_q;
  assign bus.rsp_zf     = s2_zf_q;
  assign bus.rsp_of     = s2_of_q;
  assign bus.rsp_mask   = s2_mask_q;
  assign bus.rsp_any_of = |s2_of_q;

endmodule

// File: tb/tb_valu_scheduler.sv
// ---------------------------------------------------------------------------
// tb_valu_scheduler
//   Randomized scoreboard bench for valu_scheduler. A behavioural vector
//   ALU closes the loop; accepted requests push their expected result into
//   a queue, and an independent monitor checks grants, response timing,
//   stability under backpressure and result contents.
// ---------------------------------------------------------------------------
module tb_valu_scheduler;

  localparam int THREADS = 4;
  localparam int WARPS   = 4;
  localparam int OP_W    = 4;
  localparam int WID     = 2;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_AND = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR = 4'd4;

  logic CLK;
  logic nRST;

  valu_scheduler_if #(.THREADS(THREADS), .WARPS(WARPS), .OP_W(OP_W)) bus ();

  valu_scheduler #(.THREADS(THREADS), .WARPS(WARPS), .OP_W(OP_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    int                       warp;
    logic [THREADS-1:0][31:0] out;
    logic [THREADS-1:0]       nf;
    logic [THREADS-1:0]       zf;
    logic [THREADS-1:0]       of;
    logic [THREADS-1:0]       mask;
  } exp_t;

  exp_t exp_q[$];          // written only by the issue tracker
  int   errors   = 0;      // stepped only by the monitor
  int   checks   = 0;
  int   timeouts = 0;      // directed issues that never got a grant
  bit   final_req = 1'b0;
  bit   final_done = 1'b0;

  // One lane of a 32-bit ALU: {signed overflow, result}, from plain arithmetic.
  function automatic logic [32:0] lane_ref(input logic [OP_W-1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint    sa, sb, s;
    logic [31:0] r;
    logic      ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    s   = 64'sd0;
    r   = 32'd0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin s = sa + sb; r = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB: begin s = sa - sb; r = s[31:0]; ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {ovf, r};
  endfunction

  // Expected response for warp w from its current request fields.
  function automatic exp_t build_exp(input int w);
    exp_t        e;
    logic [32:0] t;
    e.warp = w;
    e.mask = bus.req_mask[w];
    for (int l = 0; l < THREADS; l++) begin
      if (bus.req_mask[w][l]) begin
        t         = lane_ref(bus.req_op[w], bus.req_porta[w][l], bus.req_portb[w][l]);
        e.out[l]  = t[31:0];
        e.nf[l]   = t[31];
        e.zf[l]   = (t[31:0] == 32'd0);
        e.of[l]   = t[32];
      end else begin
        e.out[l]  = 32'd0;
        e.nf[l]   = 1'b0;
        e.zf[l]   = 1'b0;
        e.of[l]   = 1'b0;
      end
    end
    return e;
  endfunction

  // Behavioural vector ALU.
  logic [THREADS-1:0][32:0] alu_tmp;
  always_comb begin
    alu_tmp = '0;
    for (int l = 0; l < THREADS; l++) begin
      alu_tmp[l]       = lane_ref(bus.alu_op[l], bus.alu_porta[l], bus.alu_portb[l]);
      bus.alu_out[l]   = alu_tmp[l][31:0];
      bus.alu_nf[l]    = alu_tmp[l][31];
      bus.alu_zf[l]    = (alu_tmp[l][31:0] == 32'd0);
      bus.alu_of[l]    = alu_tmp[l][32];
    end
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue tracker: every accepted request pushes its expected result.
  always @(negedge CLK) begin
    if (nRST) begin
      for (int w = 0; w < WARPS; w++) begin
        if (bus.req_valid[w] && bus.req_ready[w]) exp_q.push_back(build_exp(w));
      end
    end
  end

  // Monitor / reference model state.
  int                       cyc = 0;
  int                       last_w = WARPS - 1;
  int                       acc_cyc[$];
  int                       rd_idx = 0;
  logic [WARPS-1:0]         exp_grant;
  bit                       found;
  int                       cand;
  bit                       exp_rv;
  bit                       prev_stall = 1'b0;
  logic [127:0]             prev_out;
  logic [15:0]              prev_flags;
  logic [WID-1:0]           prev_warp;
  exp_t                     e;

  // Monitor: grants, response timing, hold under backpressure, payload.
  always @(negedge CLK) begin
    cyc++;
    if (!nRST) begin
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_rsp_out",   bus.rsp_out, 0);
      chk("reset_alu_porta", bus.alu_porta, 0);
      acc_cyc.delete();
      last_w     = WARPS - 1;
      rd_idx     = exp_q.size();
      prev_stall = 1'b0;
    end else begin
      // Pipeline holds at most two ops; a full pipeline accepts only if
      // the result is consumed this cycle.
      exp_grant = '0;
      found     = 1'b0;
      if (acc_cyc.size() < 2 || bus.rsp_ready) begin
        for (int k = 1; k <= WARPS; k++) begin
          cand = (last_w + k) % WARPS;
          if (!found && bus.req_valid[cand]) begin
            exp_grant[cand] = 1'b1;
            found = 1'b1;
          end
        end
      end
      chk("req_ready", bus.req_ready, exp_grant);

      exp_rv = (acc_cyc.size() > 0) && ((cyc - acc_cyc[0]) >= 2);
      chk("rsp_valid", bus.rsp_valid, exp_rv);

      if (prev_stall) begin
        chk("hold_rsp_out",   bus.rsp_out, prev_out);
        chk("hold_rsp_flags", {bus.rsp_nf, bus.rsp_zf, bus.rsp_of, bus.rsp_mask}, prev_flags);
        chk("hold_rsp_warp",  bus.rsp_warp, prev_warp);
      end

      if (bus.rsp_valid && bus.rsp_ready) begin
        if (rd_idx < exp_q.size()) begin
          e = exp_q[rd_idx];
          rd_idx++;
          chk("rsp_warp",   bus.rsp_warp, e.warp);
          chk("rsp_out",    bus.rsp_out, e.out);
          chk("rsp_nf",     bus.rsp_nf, e.nf);
          chk("rsp_zf",     bus.rsp_zf, e.zf);
          chk("rsp_of",     bus.rsp_of, e.of);
          chk("rsp_mask",   bus.rsp_mask, e.mask);
          chk("rsp_any_of", bus.rsp_any_of, |e.of);
        end else begin
          chk("rsp_unexpected", bus.rsp_valid, 0);
        end
        if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      end

      for (int w = 0; w < WARPS; w++) begin
        if (bus.req_valid[w] && bus.req_ready[w]) begin
          acc_cyc.push_back(cyc);
          last_w = w;
        end
      end

      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      prev_out   = bus.rsp_out;
      prev_flags = {bus.rsp_nf, bus.rsp_zf, bus.rsp_of, bus.rsp_mask};
      prev_warp  = bus.rsp_warp;
    end

    if (final_req && !final_done) begin
      chk("all_responses_returned", rd_idx, exp_q.size());
      chk("directed_grant_timeouts", timeouts, 0);
      final_done = 1'b1;
    end
  end

  function automatic logic [31:0] pick_word();
    case ($urandom_range(5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_payload(input int w);
    bus.req_op[w] = OP_W'($urandom_range(4));
    for (int l = 0; l < THREADS; l++) begin
      bus.req_porta[w][l] = pick_word();
      bus.req_portb[w][l] = pick_word();
    end
    bus.req_mask[w] = THREADS'($urandom);
  endtask

  // Random traffic: a warp's payload only changes after acceptance or while idle.
  task automatic random_cycles(input int n, input int p_valid, input int p_ready);
    logic [WARPS-1:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      acc = bus.req_valid & bus.req_ready;
      @(posedge CLK);
      #1;
      for (int w = 0; w < WARPS; w++) begin
        if (acc[w] || !bus.req_valid[w]) begin
          if ($urandom_range(99) < p_valid) begin
            bus.req_valid[w] = 1'b1;
            rand_payload(w);
          end else begin
            bus.req_valid[w] = 1'b0;
          end
        end
      end
      bus.rsp_ready = ($urandom_range(99) < p_ready);
    end
  endtask

  task automatic issue_one(input int w, input logic [OP_W-1:0] op,
                           input logic [THREADS-1:0][31:0] a,
                           input logic [THREADS-1:0][31:0] b,
                           input logic [THREADS-1:0] mask);
    bit got;
    @(posedge CLK);
    #1;
    bus.req_valid    = '0;
    bus.rsp_ready    = 1'b1;
    bus.req_valid[w] = 1'b1;
    bus.req_op[w]    = op;
    bus.req_porta[w] = a;
    bus.req_portb[w] = b;
    bus.req_mask[w]  = mask;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge CLK);
      if (bus.req_ready[w]) got = 1'b1;
    end
    if (!got) timeouts++;
    @(posedge CLK);
    #1;
    bus.req_valid[w] = 1'b0;
    repeat (3) @(posedge CLK);
  endtask

  initial begin
    nRST          = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_porta = '0;
    bus.req_portb = '0;
    bus.req_mask  = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    // Directed cases: plain add, masked zero result, signed overflow.
    issue_one(2, OP_ADD, {4{32'd5}}, {4{32'd7}}, 4'b1111);
    issue_one(1, OP_SUB, {4{32'd3}}, {4{32'd3}}, 4'b0101);
    issue_one(0, OP_ADD, {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF},
                         {32'd0, 32'd0, 32'd0, 32'd1}, 4'b0001);
    issue_one(3, OP_XOR, {4{32'hA5A5_A5A5}}, {4{32'hFFFF_0000}}, 4'b0000);

    // All warps requesting continuously at full throughput.
    random_cycles(12, 100, 100);
    // Backpressure for five cycles, then release.
    random_cycles(5, 100, 0);
    random_cycles(8, 100, 100);

    // Fill both stages, then reset mid-cycle.
    random_cycles(3, 100, 0);
    @(posedge CLK);
    #2 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    random_cycles(8, 100, 100);

    // Mixed random traffic.
    random_cycles(300, 60, 70);

    // Drain.
    @(posedge CLK);
    #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (6) @(posedge CLK);
    final_req = 1'b1;
    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
